// File: rtl/dmem_timer_responder.sv
// Data-port responder for the reduced ARM core: byte-enabled RAM plus a
// memory-mapped down-counting timer driving the core's active-low nIRQ.
module dmem_timer_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] TIMER_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memaddr,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  be,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        nIRQ
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [1:0]  SEL_CTRL = 2'd0;
    localparam logic [1:0]  SEL_LOAD = 2'd1;
    localparam logic [1:0]  SEL_CNT  = 2'd2;
    localparam logic [1:0]  SEL_STAT = 2'd3;

    logic [31:0] r_mem [DEPTH];

    logic [2:0]  r_ctrl;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic        r_pend;
    logic        r_nirq;

    logic                  w_ram_hit;
    logic                  w_tmr_hit;
    logic [ADDR_WIDTH-1:0] w_index;
    logic [1:0]            w_sel;
    logic                  w_wr_tmr;
    logic                  w_wr_ctrl;
    logic                  w_wr_load;
    logic                  w_wr_cnt;
    logic                  w_wr_stat;
    logic                  w_expire;
    logic [2:0]            w_ctrl_nxt;
    logic [31:0]           w_load_nxt;
    logic [31:0]           w_count_nxt;
    logic                  w_pend_nxt;
    logic                  w_unused;

    // Address decode; the byte offset within a word carries no meaning here.
    assign w_ram_hit = (memaddr[31:ADDR_WIDTH+2] == '0);
    assign w_tmr_hit = (memaddr[31:4] == TIMER_BASE[31:4]);
    assign w_index   = memaddr[ADDR_WIDTH+1:2];
    assign w_sel     = memaddr[3:2];
    assign w_unused  = ^memaddr[1:0];

    assign w_wr_tmr  = memwrite && w_tmr_hit && (be == 4'hF);
    assign w_wr_ctrl = w_wr_tmr && (w_sel == SEL_CTRL);
    assign w_wr_load = w_wr_tmr && (w_sel == SEL_LOAD);
    assign w_wr_cnt  = w_wr_tmr && (w_sel == SEL_CNT);
    assign w_wr_stat = w_wr_tmr && (w_sel == SEL_STAT);

    // A software TCOUNT write pre-empts both decrement and expiry.
    assign w_expire  = r_ctrl[0] && (r_count == '0) && !w_wr_cnt;

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (memwrite && w_ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    r_mem[w_index][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    // Timer next state; expiry actions use pre-write control bits.
    always_comb begin
        w_ctrl_nxt  = r_ctrl;
        w_load_nxt  = r_load;
        w_count_nxt = r_count;
        w_pend_nxt  = r_pend;

        if (w_wr_cnt) begin
            w_count_nxt = writedata;
        end else if (r_ctrl[0] && (r_count != '0)) begin
            w_count_nxt = r_count - 32'd1;
        end else if (w_expire && r_ctrl[2]) begin
            w_count_nxt = r_load;
        end

        if (w_expire && !r_ctrl[2]) begin
            w_ctrl_nxt[0] = 1'b0;
        end
        if (w_wr_ctrl) begin
            w_ctrl_nxt = writedata[2:0];
        end

        if (w_wr_load) begin
            w_load_nxt = writedata;
        end

        if (w_wr_stat && writedata[0]) begin
            w_pend_nxt = 1'b0;
        end
        if (w_expire) begin
            w_pend_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl  <= 3'd0;
            r_load  <= 32'd0;
            r_count <= 32'd0;
            r_pend  <= 1'b0;
            r_nirq  <= 1'b1;
        end else begin
            r_ctrl  <= w_ctrl_nxt;
            r_load  <= w_load_nxt;
            r_count <= w_count_nxt;
            r_pend  <= w_pend_nxt;
            r_nirq  <= ~(w_pend_nxt & w_ctrl_nxt[1]);
        end
    end

    assign nIRQ = r_nirq;

    // Combinational read mux; unmapped or idle reads return zero.
    always_comb begin
        readdata = 32'd0;
        if (memread) begin
            if (w_ram_hit) begin
                readdata = r_mem[w_index];
            end else if (w_tmr_hit) begin
                unique case (w_sel)
                    SEL_CTRL: readdata = {29'd0, r_ctrl};
                    SEL_LOAD: readdata = r_load;
                    SEL_CNT:  readdata = r_count;
                    SEL_STAT: readdata = {31'd0, r_pend};
                    default:  readdata = 32'd0;
                endcase
            end
        end
    end

endmodule
